// File: rtl/adc_sampler_pkg.sv
// Shared types, defaults and timing helpers for the SPI ADC acquisition sequencer.
package adc_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } frame_state_e;

  localparam int CLK_HZ             = 6_000_000;
  localparam int SAMPLE_HZ          = 10_000;
  localparam int DEF_DATA_W         = 12;
  localparam int DEF_FRAME_BITS     = 16;
  localparam int DEF_SCLK_DIV       = 3;
  localparam int DEF_SAMPLE_PERIOD  = CLK_HZ / SAMPLE_HZ;

  // Chip-select low time: setup and hold halves plus FRAME_BITS full SCLK periods.
  function automatic int frame_cycles(input int sclk_div, input int frame_bits);
    return 2 * sclk_div * (frame_bits + 1);
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// One SPI mode-0 conversion frame per start pulse: CS/SCLK sequencing and MISO capture.
// done pulses in the last HOLD cycle; word holds the last DATA_W bits shifted in, MSB first.
module spi_frame_shifter
  import adc_sampler_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int SCLK_DIV   = DEF_SCLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk,
  output logic              done,
  output logic [DATA_W-1:0] word
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END = BW'(FRAME_BITS - 1);

  frame_state_e  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic          cs_nxt, sclk_nxt, capture, half_end;

  assign half_end = (cnt == CNT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      cs_n    <= cs_nxt;
      sclk    <= sclk_nxt;
    end
  end

  // SETUP doubles as the low half before the first rise; each bit is then high
  // followed by low, and HOLD adds the trailing gap before CS is released.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = half_end ? '0 : cnt + 1'b1;
    bit_nxt   = bit_cnt;
    cs_nxt    = cs_n;
    sclk_nxt  = sclk;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = SETUP;
          cs_nxt    = 1'b0;
        end
      end
      SETUP: begin
        if (half_end) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b1;
          capture   = 1'b1;
          bit_nxt   = '0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (sclk) begin
            sclk_nxt = 1'b0;
          end else if (bit_cnt == BIT_END) begin
            state_nxt = HOLD;
          end else begin
            sclk_nxt = 1'b1;
            capture  = 1'b1;
            bit_nxt  = bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          state_nxt = IDLE;
          cs_nxt    = 1'b1;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word <= '0;
    else if (capture) word <= (word << 1) | DATA_W'(miso);
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI ADC sampler: rate counter, frame sequencer, valid/ready result register.
// Optional 4-frame averaging when ADC_SAMPLER_AVG4_EN is defined.
module adc_spi_sampler
  import adc_sampler_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int FRAME_BITS    = DEF_FRAME_BITS,
  parameter int SCLK_DIV      = DEF_SCLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_miso,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic [15:0]       sample_cnt
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] PER_END = PW'(SAMPLE_PERIOD - 1);

  logic [PW-1:0]     per_cnt;
  logic              tick, frame_done, load_req, load, xfer;
  logic [DATA_W-1:0] frame_word, load_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 per_cnt <= '0;
    else if (!en)               per_cnt <= '0;
    else if (per_cnt == PER_END) per_cnt <= '0;
    else                        per_cnt <= per_cnt + 1'b1;
  end

  // The shifter ignores start outside IDLE, so a dropped en never truncates a frame.
  assign tick = en && (per_cnt == '0);

  spi_frame_shifter #(
    .DATA_W    (DATA_W),
    .FRAME_BITS(FRAME_BITS),
    .SCLK_DIV  (SCLK_DIV)
  ) u_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tick),
    .miso (adc_miso),
    .cs_n (adc_cs_n),
    .sclk (adc_sclk),
    .done (frame_done),
    .word (frame_word)
  );

`ifdef ADC_SAMPLER_AVG4_EN
  logic [DATA_W+1:0] acc, sum;
  logic [1:0]        grp;

  assign sum = acc + {2'b00, frame_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      grp <= '0;
    end else if (!en) begin
      acc <= '0;
      grp <= '0;
    end else if (frame_done) begin
      acc <= (grp == 2'd3) ? '0 : sum;
      grp <= grp + 1'b1;
    end
  end

  assign load_req  = frame_done && en && (grp == 2'd3);
  assign load_word = sum[DATA_W+1:2];
`else
  assign load_req  = frame_done;
  assign load_word = frame_word;
`endif

  assign xfer = sample_valid && sample_ready;
  assign load = load_req && (!sample_valid || sample_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      sample_cnt   <= '0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        sample_data  <= load_word;
        sample_valid <= 1'b1;
      end else if (xfer) begin
        sample_valid <= 1'b0;
      end
      if (xfer) sample_cnt <= sample_cnt + 1'b1;
      if (!en)                   overrun <= 1'b0;
      else if (load_req && !load) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Periodic SPI ADC acquisition sequencer clocked by the 6 MHz output of the 60→6 MHz rPLL on the data-acquisition protoboard. It generates conversion frames (CS_N/SCLK, mode 0) at a fixed sample rate and shifts in one ADC word per frame. It presents each result on a valid/ready output register for the downstream buffering/transmit logic, and flags dropped samples.

## Interface
- `DATA_W`, 12: ADC result width; the last `DATA_W` bits of the frame, MSB first.
- `FRAME_BITS`, 16: SCLK cycles per frame; requires `FRAME_BITS >= DATA_W`.
- `SCLK_DIV`, 3: SCLK half-period in `clk` cycles; requires ≥1. Default gives 1 MHz SCLK.
- `SAMPLE_PERIOD`, 600: `clk` cycles between frame starts; default gives 10 kS/s. Requires `SAMPLE_PERIOD > FRAME_CYCLES + 1`, where `FRAME_CYCLES = 2*SCLK_DIV*(FRAME_BITS+1)` (102 by default).

Ports:
- `clk` in 1: 6 MHz acquisition clock, driven by the PLL `clkout`.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: sampling enable.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: SPI clock; idles low.
- `adc_miso` in 1: ADC serial data, already synchronised externally.
- `sample_data` out `DATA_W`: result word.
- `sample_valid` out 1: result available.
- `sample_ready` in 1: consumer accepts the result.
- `overrun` out 1: sticky flag; a completed sample was dropped.
- `sample_cnt` out 16: count of accepted samples; wraps at 0xFFFF→0.

## Operation
- **Rate counter**
  - `per_cnt` is held at 0 while `en`=0.
  - When `en`=1 it counts 0..`SAMPLE_PERIOD`-1 and wraps.
  - A tick fires on any cycle where `en`=1 and `per_cnt`=0.
- **FSM states:** IDLE, SETUP, SHIFT, HOLD.
  - IDLE→SETUP on a tick. A tick arriving in any other state is ignored; parameter rules prevent this.
  - SETUP: `adc_cs_n`=0 for `SCLK_DIV` cycles, then go to SHIFT.
  - SHIFT: `FRAME_BITS` full SCLK periods. `adc_sclk` rises after each low half-period, and `adc_miso` is sampled on the `clk` edge where SCLK goes high. Data shifts in MSB first, and only the last `DATA_W` bits are kept.
  - HOLD: SCLK low, CS_N still low, for `SCLK_DIV` cycles, then go to IDLE with `adc_cs_n`=1.
- **Output register**
  - At the end of a frame, if `sample_valid`=0 or `sample_ready`=1 in that same cycle, load `sample_data` and set `sample_valid`.
  - Otherwise discard the new word, keep the old word, and set `overrun`.
- **Handshake:** a transfer occurs when `sample_valid && sample_ready`. `sample_cnt` increments on each transfer. `sample_valid` clears on a transfer unless a new load happens in the same cycle.
- **`overrun`:** cleared only by reset or by `en`=0.
- **`en` falling mid-frame:** the frame completes normally, with no CS/SCLK truncation, and its result is delivered. No further ticks occur.
- **Reset values:**
  - `adc_cs_n`=1, `adc_sclk`=0
  - `sample_valid`=0, `sample_data`=0
  - `overrun`=0, `sample_cnt`=0
  - FSM in IDLE
- **Reset mid-frame:** outputs take their reset values immediately, asynchronously.

## Timing
- All outputs are registered.
- For a tick at cycle T:
  - `adc_cs_n` falls at T+1.
  - First SCLK rise at T+1+`SCLK_DIV`.
  - `adc_cs_n` rises at T+1+`FRAME_CYCLES`.
  - `sample_valid` rises in the same cycle as `adc_cs_n`. Default: T+103.
- SCLK duty is exactly 50%. The CS-to-first-edge and last-edge-to-CS gaps are each `SCLK_DIV` cycles.
- Ticks occur at T, T+`SAMPLE_PERIOD`, T+2·`SAMPLE_PERIOD`, and so on. The first tick is on the first cycle with `en`=1.

## Configuration
- **`ADC_SAMPLER_AVG4_EN` defined:**
  - Four consecutive frames are summed in a (`DATA_W`+2)-bit accumulator.
  - The output register loads `sum>>2` (truncated) only after every 4th frame. `sample_valid` therefore rises at most once per 4·`SAMPLE_PERIOD`.
  - Overrun is evaluated only at those loads.
  - `en`=0 clears the accumulator and the frame counter; a partial group is discarded.
- **Undefined:** every frame loads directly; there is no accumulator logic.

## Structure
- **Package `adc_sampler_pkg`:** FSM state enum (IDLE/SETUP/SHIFT/HOLD), the `FRAME_CYCLES` calculation function, and default constants (6 MHz clock, 10 kS/s).
- **Sub-module `spi_frame_shifter`:** SETUP/SHIFT/HOLD sequencing and the MISO shift register, with a start/done interface. The top level holds the rate counter, output register, averaging and counters.

## Test plan
- **Basic frame:** ADC model returns 16'h5ABC, `en`=1, `sample_ready`=1 → `sample_data`=12'hABC, valid at T+103, CS_N low for exactly 102 cycles, 16 SCLK rises, `sample_cnt`=1.
- **Rate:** `en` held high for 6000 cycles → exactly 10 frames, starts spaced 600 cycles apart.
- **Backpressure:** `sample_ready`=0 across two frames with data 0x111 then 0x222 → `sample_data` stays 0x111, `overrun`=1. Raising ready gives one transfer; a later `en` low clears `overrun`.
- **Same-cycle accept and load:** ready asserted exactly at the frame-end cycle → new word loads, `sample_valid` stays 1, `sample_cnt` increments, no overrun.
- **`en` drop mid-frame (cycle T+50), then reset mid-frame on the next run:** first case → frame completes, one sample delivered, no further CS activity. Second case (`rst_n` low at T+40) → `adc_cs_n`=1 and `adc_sclk`=0 immediately, `sample_valid`=0.
- **With `ADC_SAMPLER_AVG4_EN`:** samples 100, 101, 102, 104 → one output of 101 after the 4th frame and none before.
